// File: rtl/div_seq_ctrl_pkg.sv
// Shared types and defaults for the sequential divider controller.
// Latency: none (declarations only). Backpressure: n/a.
// Holds the FSM state encoding and the default datapath/tag widths.
package div_seq_ctrl_pkg;

    localparam int DIV_DATA_W = 32;
    localparam int DIV_TAG_W  = 5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } div_st_e;

endpackage

// File: rtl/div_radix2_step.sv
// One restoring radix-2 division step on the {rem,quot} shift pair.
// Latency: combinational. Backpressure: n/a.
// Assumes rem_i < div_i on entry (holds for every non-zero divisor).
module div_radix2_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] quot_i,
    input  logic [W-1:0] div_i,
    output logic [W-1:0] rem_o,
    output logic [W-1:0] quot_o
);

    logic [W:0] shifted;
    logic [W:0] diff;

    assign shifted = {rem_i, quot_i[W-1]};
    assign diff    = shifted - {1'b0, div_i};

    // Borrow out of the W+1 bit subtract means the trial failed: restore.
    assign rem_o  = diff[W] ? shifted[W-1:0] : diff[W-1:0];
    assign quot_o = {quot_i[W-2:0], ~diff[W]};

endmodule

// File: rtl/div_seq_ctrl.sv
// Divider sequencer: IDLE->PREP->ITER->FIX->DONE for div/mod signed/unsigned; DIV_EARLY_OUT_EN skips ITER.
// Latency: accept to out_valid DATA_W+3 cycles (3 on early-out). Backpressure: result held in DONE until out_ready.
// in_ready only in IDLE; flush cancels from any state, masking in_ready.
module div_seq_ctrl
    import div_seq_ctrl_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W,
    parameter int TAG_W  = DIV_TAG_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_signed,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_quot,
    output logic [DATA_W-1:0] out_rem,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W);

    div_st_e           state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] quot_q, quot_d;
    logic [DATA_W-1:0] dvsr_q, dvsr_d;
    logic [DATA_W-1:0] res_quot_q, res_quot_d;
    logic [DATA_W-1:0] res_rem_q, res_rem_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              sgn_q, sgn_d;
    logic              neg_quot_q, neg_quot_d;
    logic              neg_rem_q, neg_rem_d;
    logic              bzero_q, bzero_d;

    logic [DATA_W-1:0] a_mag, b_mag;
    logic [DATA_W-1:0] step_rem, step_quot;

    assign a_mag = (sgn_q && a_q[DATA_W-1]) ? -a_q : a_q;
    assign b_mag = (sgn_q && b_q[DATA_W-1]) ? -b_q : b_q;

    div_radix2_step #(.W(DATA_W)) u_step (
        .rem_i  (rem_q),
        .quot_i (quot_q),
        .div_i  (dvsr_q),
        .rem_o  (step_rem),
        .quot_o (step_quot)
    );

    assign in_ready  = (state_q == ST_IDLE) && !flush;
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_quot  = res_quot_q;
    assign out_rem   = res_rem_q;
    assign out_tag   = tag_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        dvsr_d     = dvsr_q;
        res_quot_d = res_quot_q;
        res_rem_d  = res_rem_q;
        tag_d      = tag_q;
        sgn_d      = sgn_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        bzero_d    = bzero_q;

        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        a_d     = in_a;
                        b_d     = in_b;
                        sgn_d   = in_signed;
                        tag_d   = in_tag;
                        state_d = ST_PREP;
                    end
                end
                ST_PREP: begin
                    quot_d     = a_mag;
                    rem_d      = '0;
                    dvsr_d     = b_mag;
                    neg_quot_d = sgn_q && (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
                    neg_rem_d  = sgn_q && a_q[DATA_W-1];
                    bzero_d    = (b_q == '0);
                    cnt_d      = CNT_W'(DATA_W - 1);
                    state_d    = ST_ITER;
`ifdef DIV_EARLY_OUT_EN
                    // Quotient is already known to be zero (or forced for b==0 in FIX).
                    if ((b_q == '0) || (a_mag < b_mag)) begin
                        quot_d  = '0;
                        rem_d   = a_mag;
                        cnt_d   = '0;
                        state_d = ST_FIX;
                    end
`endif
                end
                ST_ITER: begin
                    rem_d  = step_rem;
                    quot_d = step_quot;
                    if (cnt_q == '0) begin
                        state_d = ST_FIX;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_FIX: begin
                    if (bzero_q) begin
                        res_quot_d = '1;
                        res_rem_d  = a_q;
                    end else begin
                        res_quot_d = neg_quot_q ? -quot_q : quot_q;
                        res_rem_d  = neg_rem_q ? -rem_q : rem_q;
                    end
                    state_d = ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            dvsr_q     <= '0;
            res_quot_q <= '0;
            res_rem_q  <= '0;
            tag_q      <= '0;
            sgn_q      <= 1'b0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            bzero_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            dvsr_q     <= dvsr_d;
            res_quot_q <= res_quot_d;
            res_rem_q  <= res_rem_d;
            tag_q      <= tag_d;
            sgn_q      <= sgn_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            bzero_q    <= bzero_d;
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: directed ops with literal results plus a per-cycle reference model.
module tb_div_seq_ctrl;

    localparam int DW = 32;
    localparam int TW = 5;
    localparam int FULL_LAT = DW + 3;
`ifdef DIV_EARLY_OUT_EN
    localparam int SHORT_LAT = 3;
`else
    localparam int SHORT_LAT = FULL_LAT;
`endif

    logic          clk;
    logic          resetn;
    logic          in_valid;
    logic          in_ready;
    logic          in_signed;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic [TW-1:0] in_tag;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_quot;
    logic [DW-1:0] out_rem;
    logic [TW-1:0] out_tag;
    logic          busy;

    int n_chk  = 0;
    int n_pass = 0;

    div_seq_ctrl #(.DATA_W(DW), .TAG_W(TW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_quot  (out_quot),
        .out_rem   (out_rem),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Reference: plain integer division semantics plus the divide-by-zero rule.
    function automatic void model(input bit s, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                  output logic [DW-1:0] q, output logic [DW-1:0] r, output int lat);
        longint sa, sb;
        logic [DW-1:0] ma, mb;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = DW'(sa / sb);
            r = DW'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        ma = (s && a[DW-1]) ? DW'(-longint'($signed(a))) : a;
        mb = (s && b[DW-1]) ? DW'(-longint'($signed(b))) : b;
        lat = FULL_LAT;
        if (b == '0 || ma < mb) lat = SHORT_LAT;
    endfunction

    logic [DW-1:0] m_q, m_r;
    logic [TW-1:0] m_tag;
    int            m_lat, m_age;
    bit            m_act = 1'b0;
    bit            c_acc, c_hs, c_vld;

    always @(posedge clk) begin
        c_acc = resetn && in_valid && !m_act && !flush;
        c_hs  = m_act && (m_age >= m_lat) && out_ready;
        if (!resetn || flush || c_hs) m_act = 1'b0;
        else if (m_act) m_age++;
        if (c_acc) begin
            model(in_signed, in_a, in_b, m_q, m_r, m_lat);
            m_tag = in_tag;
            m_act = 1'b1;
            m_age = 1;
        end
        #1;
        c_vld = m_act && (m_age >= m_lat);
        chk("cyc_out_valid", out_valid, c_vld);
        chk("cyc_busy", busy, m_act);
        chk("cyc_in_ready", in_ready, !m_act && !flush);
        if (c_vld) begin
            chk("cyc_quot", out_quot, m_q);
            chk("cyc_rem", out_rem, m_r);
            chk("cyc_tag", out_tag, m_tag);
        end
    end

    task automatic run_op(input bit s, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [TW-1:0] tag, input int hold,
                          input logic [DW-1:0] eq, input logic [DW-1:0] er, input int elat);
        int n;
        @(negedge clk);
        in_valid = 1'b1; in_signed = s; in_a = a; in_b = b; in_tag = tag; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("op_latency", 64'(n), 64'(elat));
        chk("op_quot", out_quot, eq);
        chk("op_rem", out_rem, er);
        chk("op_tag", out_tag, tag);
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_quot", out_quot, eq);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_hs_valid", out_valid, 1'b0);
        chk("post_hs_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        resetn = 1'b0; in_valid = 1'b0; in_signed = 1'b0; in_a = '0; in_b = '0;
        in_tag = '0; flush = 1'b0; out_ready = 1'b0;
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_quot", out_quot, 32'h0);
        chk("rst_rem", out_rem, 32'h0);
        chk("rst_tag", out_tag, 5'h0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);

        run_op(1'b0, 32'd100, 32'd7, 5'd1, 0, 32'd14, 32'd2, FULL_LAT);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 5'd2, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, FULL_LAT);
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 5'd3, 0, 32'hFFFF_FFFD, 32'd1, FULL_LAT);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 0, 32'h8000_0000, 32'd0, FULL_LAT);
        run_op(1'b0, 32'd1234, 32'd0, 5'd5, 0, 32'hFFFF_FFFF, 32'd1234, SHORT_LAT);
        run_op(1'b1, 32'hFFFF_FFFB, 32'd0, 5'd6, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, SHORT_LAT);
        run_op(1'b0, 32'hFFFF_FFFF, 32'd16, 5'd7, 20, 32'h0FFF_FFFF, 32'hF, FULL_LAT);

        // Flush during ITER cycle 10, then a clean op must still complete.
        @(negedge clk);
        in_valid = 1'b1; in_signed = 1'b0; in_a = 32'd100; in_b = 32'd7; in_tag = 5'd12;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", busy, 1'b0);
        chk("flush_valid", out_valid, 1'b0);
        repeat (40) @(negedge clk);
        run_op(1'b0, 32'd9, 32'd3, 5'd9, 0, 32'd3, 32'd0, FULL_LAT);

        // A request coinciding with flush in IDLE is dropped.
        @(negedge clk);
        in_valid = 1'b1; in_a = 32'd50; in_b = 32'd5; in_tag = 5'd10; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_idle_busy", busy, 1'b0);

        // Asynchronous reset mid-ITER clears everything before the next edge.
        @(negedge clk);
        in_valid = 1'b1; in_a = 32'd200; in_b = 32'd3; in_tag = 5'd13;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (14) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_quot", out_quot, 32'h0);
        chk("arst_rem", out_rem, 32'h0);
        chk("arst_tag", out_tag, 5'h0);
        @(negedge clk);
        resetn = 1'b1;

        run_op(1'b0, 32'd3, 32'd5, 5'd11, 0, 32'd0, 32'd3, SHORT_LAT);
        run_op(1'b1, 32'hFFFF_FFFD, 32'd5, 5'd14, 0, 32'd0, 32'hFFFF_FFFD, SHORT_LAT);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
